// File: rtl/category_argmax_seq.sv
// category_argmax_seq
//
// Sequential arg-max classifier over vote bit vectors. A start request takes
// a snapshot of every class's vote bits. The block then popcounts CHUNK bits
// of one class per cycle and accumulates a per-class total. When a class's
// final chunk is counted, that total is compared against the running best
// and second-best totals. After the last class, the winning index, its
// popcount and the margin to the runner-up are published together with a
// one-cycle done pulse.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   snapshot categories and classify (ignored while busy)
//   categories  in   CATEGORIES*BITS_PER_CATEGORY vote bits, class i at
//                    [i*BITS_PER_CATEGORY +: BITS_PER_CATEGORY]
//   busy        out  high while chunks are being counted
//   done        out  one-cycle pulse when the result outputs update
//   best_index  out  index of the class with the highest popcount
//   best_value  out  popcount of that class
//   margin      out  best_value minus the second-highest popcount
module category_argmax_seq #(
  parameter  int CATEGORIES        = 10,
  parameter  int BITS_PER_CATEGORY = 511,
  parameter  int CHUNK             = 64,
  localparam int SUM_W             = $clog2(BITS_PER_CATEGORY + 1),
  localparam int IDX_W             = $clog2(CATEGORIES)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [CATEGORIES*BITS_PER_CATEGORY-1:0] categories,
  output logic                                    busy,
  output logic                                    done,
  output logic [IDX_W-1:0]                        best_index,
  output logic [SUM_W-1:0]                        best_value,
  output logic [SUM_W-1:0]                        margin
);

  localparam int CHUNKS  = (BITS_PER_CATEGORY + CHUNK - 1) / CHUNK;
  localparam int NCHUNK  = CATEGORIES * CHUNKS;
  localparam int KW      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int TOTAL_W = CATEGORIES * BITS_PER_CATEGORY;

  localparam logic [KW-1:0]    K_LAST = KW'(CHUNKS - 1);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(CATEGORIES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Population count of one chunk. A chunk never holds more bits than a
  // whole class, so SUM_W bits cannot overflow.
  function automatic logic [SUM_W-1:0] popcount(input logic [CHUNK-1:0] v);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) begin
      n = n + SUM_W'(v[i]);
    end
    return n;
  endfunction

  state_t             state_q, state_d;
  logic [TOTAL_W-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]   c_q, c_d;
  logic [KW-1:0]      k_q, k_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]   best_q, best_d;
  logic [SUM_W-1:0]   second_q, second_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   best_index_q, best_index_d;
  logic [SUM_W-1:0]   best_value_q, best_value_d;
  logic [SUM_W-1:0]   margin_q, margin_d;

  logic [CHUNK-1:0]   chunk_arr [NCHUNK];
  logic [CHUNK-1:0]   chunk_bits;
  logic [SUM_W-1:0]   chunk_pop;
  logic [SUM_W-1:0]   total;
  int                 chunk_sel;

  // Each class is split into CHUNKS slices of CHUNK bits. The last slice of
  // a class may be short. It is zero-extended so that it never reads into
  // the next class's bits.
  for (genvar g = 0; g < CATEGORIES; g++) begin : g_cls
    for (genvar h = 0; h < CHUNKS; h++) begin : g_chk
      localparam int LO  = g * BITS_PER_CATEGORY + h * CHUNK;
      localparam int REM = BITS_PER_CATEGORY - h * CHUNK;
      localparam int N   = (REM < CHUNK) ? REM : CHUNK;
      if (N == CHUNK) begin : g_full
        assign chunk_arr[g*CHUNKS+h] = snap_q[LO +: CHUNK];
      end else begin : g_part
        assign chunk_arr[g*CHUNKS+h] = {{(CHUNK-N){1'b0}}, snap_q[LO +: N]};
      end
    end
  end

  always_comb begin
    chunk_sel  = int'(c_q) * CHUNKS + int'(k_q);
    chunk_bits = '0;
    for (int t = 0; t < NCHUNK; t++) begin
      if (chunk_sel == t) begin
        chunk_bits = chunk_arr[t];
      end
    end
  end

  assign chunk_pop = popcount(chunk_bits);

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    c_d          = c_q;
    k_d          = k_q;
    acc_d        = acc_q;
    best_d       = best_q;
    second_d     = second_q;
    idx_d        = idx_q;
    best_index_d = best_index_q;
    best_value_d = best_value_q;
    margin_d     = margin_q;
    total        = acc_q + chunk_pop;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = COUNT;
          snap_d  = categories;
          c_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      COUNT: begin
        if (k_q == K_LAST) begin
          acc_d = '0;
          k_d   = '0;
          c_d   = (c_q == C_LAST) ? '0 : c_q + 1'b1;
          // Strict greater-than keeps the earlier class on a tie. An equal
          // total still falls into the second-best branch, so a tie for
          // first place produces a zero margin.
          if (c_q == '0) begin
            best_d   = total;
            second_d = '0;
            idx_d    = '0;
          end else if (total > best_q) begin
            second_d = best_q;
            best_d   = total;
            idx_d    = c_q;
          end else if (total > second_q) begin
            second_d = total;
          end
          if (c_q == C_LAST) begin
            state_d      = DONE;
            best_index_d = idx_d;
            best_value_d = best_d;
            margin_d     = best_d - second_d;
          end
        end else begin
          acc_d = total;
          k_d   = k_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      c_q          <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      best_q       <= '0;
      second_q     <= '0;
      idx_q        <= '0;
      best_index_q <= '0;
      best_value_q <= '0;
      margin_q     <= '0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      best_q       <= best_d;
      second_q     <= second_d;
      idx_q        <= idx_d;
      best_index_q <= best_index_d;
      best_value_q <= best_value_d;
      margin_q     <= margin_d;
    end
    // The snapshot is only read while counting, after a start has loaded it.
    snap_q <= snap_d;
  end

  assign busy       = (state_q == COUNT);
  assign done       = (state_q == DONE);
  assign best_index = best_index_q;
  assign best_value = best_value_q;
  assign margin     = margin_q;

endmodule

// File: tb/tb_category_argmax_seq.sv
// Testbench for category_argmax_seq. It uses a default-size instance
// (10 classes x 511 bits, 64-bit chunks) and a small instance
// (3 classes x 100 bits, 32-bit chunks) to cover a final chunk that is
// only partly filled.
module tb_category_argmax_seq;

  localparam int CAT1 = 10, BPC1 = 511, CH1 = 64;
  localparam int CAT2 = 3,  BPC2 = 100, CH2 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start;
  logic [CAT1*BPC1-1:0] cats;
  logic                 busy, done;
  logic [3:0]           bidx;
  logic [8:0]           bval, marg;

  logic                 rst2, start2;
  logic [CAT2*BPC2-1:0] cats2;
  logic                 busy2, done2;
  logic [1:0]           bidx2;
  logic [6:0]           bval2, marg2;

  int n_cmp = 0;
  int n_bad = 0;

  category_argmax_seq #(
    .CATEGORIES(CAT1), .BITS_PER_CATEGORY(BPC1), .CHUNK(CH1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .categories(cats),
    .busy(busy), .done(done), .best_index(bidx), .best_value(bval),
    .margin(marg)
  );

  category_argmax_seq #(
    .CATEGORIES(CAT2), .BITS_PER_CATEGORY(BPC2), .CHUNK(CH2)
  ) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .categories(cats2),
    .busy(busy2), .done(done2), .best_index(bidx2), .best_value(bval2),
    .margin(marg2)
  );

  // Gives class cls of the big instance n ones in its low bits.
  task automatic set_class(input int cls, input int n);
    logic [BPC1-1:0] m;
    m = '1;
    m = m >> (BPC1 - n);
    cats[cls*BPC1 +: BPC1] = m;
  endtask

  // Raises start for one edge. On return, the accepting edge has passed.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Watches the big instance after an accepting edge. Sample i is taken i
  // edges after acceptance. Counts busy samples and done pulses, and records
  // the edge of the first done.
  task automatic run_wait(input int maxc, output int busy_n, output int done_n,
                          output int first_done);
    busy_n = 0; done_n = 0; first_done = -1;
    for (int i = 0; i <= maxc; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (first_done < 0) first_done = i;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
    cats = '0; cats2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0d want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0d want 0", done); end
    n_cmp++; if (bidx !== 4'd0) begin n_bad++; $display("FAIL reset_index: got %0d want 0", bidx); end
    n_cmp++; if (bval !== 9'd0) begin n_bad++; $display("FAIL reset_value: got %0d want 0", bval); end
    n_cmp++; if (marg !== 9'd0) begin n_bad++; $display("FAIL reset_margin: got %0d want 0", marg); end
    n_cmp++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin n_bad++; $display("FAIL reset_small_ctrl: got busy=%0d done=%0d want 0/0", busy2, done2); end
    rst = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_winner();
    int bn, dn, fd;
    cats = '0;
    set_class(3, 511);
    pulse_start();
    run_wait(90, bn, dn, fd);
    n_cmp++; if (bn !== 80) begin n_bad++; $display("FAIL single_busy_cycles: got %0d want 80", bn); end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", dn); end
    n_cmp++; if (fd !== 80) begin n_bad++; $display("FAIL single_done_latency: got %0d want 80", fd); end
    n_cmp++; if (bidx !== 4'd3) begin n_bad++; $display("FAIL single_index: got %0d want 3", bidx); end
    n_cmp++; if (bval !== 9'd511) begin n_bad++; $display("FAIL single_value: got %0d want 511", bval); end
    n_cmp++; if (marg !== 9'd511) begin n_bad++; $display("FAIL single_margin: got %0d want 511", marg); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_after: got busy=%0d want 0", busy); end
  endtask

  task automatic test_tie_snapshot();
    int dn, fd;
    for (int c = 0; c < CAT1; c++) set_class(c, 100);
    set_class(2, 300);
    set_class(7, 300);
    pulse_start();
    dn = 0; fd = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 5)  cats = ~cats;
      if (i == 10) start = 1'b1;
      if (i == 11) start = 1'b0;
      if (done) begin
        dn++;
        if (fd < 0) fd = i;
      end
    end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL tie_done_count: got %0d want 1", dn); end
    n_cmp++; if (fd !== 80) begin n_bad++; $display("FAIL tie_done_latency: got %0d want 80", fd); end
    n_cmp++; if (bidx !== 4'd2) begin n_bad++; $display("FAIL tie_index: got %0d want 2", bidx); end
    n_cmp++; if (bval !== 9'd300) begin n_bad++; $display("FAIL tie_value: got %0d want 300", bval); end
    n_cmp++; if (marg !== 9'd0) begin n_bad++; $display("FAIL tie_margin: got %0d want 0", marg); end
  endtask

  task automatic test_reset_mid_run();
    int bn, dn, fd;
    cats = '0;
    set_class(4, 500);
    pulse_start();
    repeat (39) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before: got %0d want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL midrst_ctrl: got busy=%0d done=%0d want 0/0", busy, done); end
    n_cmp++; if (bidx !== 4'd0 || bval !== 9'd0 || marg !== 9'd0) begin n_bad++; $display("FAIL midrst_outputs: got %0d/%0d/%0d want 0/0/0", bidx, bval, marg); end
    dn = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d want 0", dn); end
    cats = '0;
    set_class(9, 200);
    set_class(8, 150);
    pulse_start();
    run_wait(85, bn, dn, fd);
    n_cmp++; if (fd !== 80 || dn !== 1) begin n_bad++; $display("FAIL midrst_rerun_done: got edge=%0d count=%0d want 80/1", fd, dn); end
    n_cmp++; if (bidx !== 4'd9) begin n_bad++; $display("FAIL midrst_index: got %0d want 9", bidx); end
    n_cmp++; if (bval !== 9'd200) begin n_bad++; $display("FAIL midrst_value: got %0d want 200", bval); end
    n_cmp++; if (marg !== 9'd50) begin n_bad++; $display("FAIL midrst_margin: got %0d want 50", marg); end
  endtask

  task automatic test_back_to_back();
    int bn, dn, fd;
    cats = '0;
    set_class(5, 400);
    set_class(1, 390);
    pulse_start();
    fd = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        fd = i;
        break;
      end
    end
    n_cmp++; if (fd !== 80) begin n_bad++; $display("FAIL b2b_first_done: got %0d want 80", fd); end
    n_cmp++; if (bidx !== 4'd5 || bval !== 9'd400 || marg !== 9'd10) begin n_bad++; $display("FAIL b2b_first_result: got %0d/%0d/%0d want 5/400/10", bidx, bval, marg); end
    // Start is held through the DONE cycle.
    cats = '0;
    set_class(0, 10);
    set_class(9, 10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL b2b_restart: got busy=%0d done=%0d want 1/0", busy, done); end
    n_cmp++; if (bidx !== 4'd5 || bval !== 9'd400) begin n_bad++; $display("FAIL b2b_hold: got %0d/%0d want 5/400", bidx, bval); end
    run_wait(85, bn, dn, fd);
    n_cmp++; if (bn !== 80 || fd !== 80 || dn !== 1) begin n_bad++; $display("FAIL b2b_second_run: got busy=%0d edge=%0d count=%0d want 80/80/1", bn, fd, dn); end
    n_cmp++; if (bidx !== 4'd0 || bval !== 9'd10 || marg !== 9'd0) begin n_bad++; $display("FAIL b2b_second_result: got %0d/%0d/%0d want 0/10/0", bidx, bval, marg); end
  endtask

  task automatic test_non_divisible();
    logic [BPC2-1:0] m;
    int bn, dn, fd;
    m = '1;
    cats2[0 +: BPC2]      = m;
    cats2[BPC2 +: BPC2]   = (m >> 1) << 1;
    cats2[2*BPC2 +: BPC2] = m >> 50;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    bn = 0; dn = 0; fd = -1;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (busy2) bn++;
      if (done2) begin
        dn++;
        if (fd < 0) fd = i;
      end
    end
    n_cmp++; if (bn !== 12) begin n_bad++; $display("FAIL nondiv_busy_cycles: got %0d want 12", bn); end
    n_cmp++; if (fd !== 12 || dn !== 1) begin n_bad++; $display("FAIL nondiv_done: got edge=%0d count=%0d want 12/1", fd, dn); end
    n_cmp++; if (bidx2 !== 2'd0) begin n_bad++; $display("FAIL nondiv_index: got %0d want 0", bidx2); end
    n_cmp++; if (bval2 !== 7'd100) begin n_bad++; $display("FAIL nondiv_value: got %0d want 100", bval2); end
    n_cmp++; if (marg2 !== 7'd1) begin n_bad++; $display("FAIL nondiv_margin: got %0d want 1", marg2); end
  endtask

  initial begin
    test_reset();
    test_single_winner();
    test_tie_snapshot();
    test_reset_mid_run();
    test_back_to_back();
    test_non_divisible();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
